// File: rtl/mem_responder.sv
// Memory-mapped responder for a multiplexed-bus CPU: 256x16 RAM, a small
// register bank, programmable wait states and a reload timer driving nIrq.
module mem_responder #(
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic [DATA_W-1:0] DataOut,
   input  logic              Ale,
   input  logic              nMe,
   input  logic              RnW,
   input  logic              nOe,
   input  logic              Enb,
   output logic [DATA_W-1:0] DataIn,
   output logic              nWait,
   output logic              nIrq
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

   state_t            state_q;
   logic [15:0]       addr_q;
   logic [1:0]        wcnt_q;
   logic [1:0]        waitcfg_q;
   logic              nwait_q;
   logic              nirq_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] reload_q;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] ram_q [256];

   logic              acc_edge, wr_edge, defer, ram_we, reg_we, expire;
   logic [DATA_W-1:0] rd_target;
   logic              unused_addr_bits;

   // Address bits 14:8 alias the RAM and are deliberately not decoded.
   assign unused_addr_bits = ^addr_q[14:8];

   assign acc_edge = (state_q == ADDR || state_q == WAIT) && !Ale && !nMe && (wcnt_q == 2'd0);
   assign wr_edge  = acc_edge && !RnW && Enb;
   assign defer    = acc_edge && !RnW && !Enb;
   assign ram_we   = wr_edge && !addr_q[15];
   assign reg_we   = wr_edge && addr_q[15];
   assign expire   = (reload_q != '0) && (cnt_q == DATA_W'(1));

   always_comb begin
      rd_target = '0;
      if (!addr_q[15]) begin
         rd_target = ram_q[addr_q[7:0]];
      end else begin
         case (addr_q[1:0])
            2'd0:    rd_target = {{(DATA_W-2){1'b0}}, waitcfg_q};
            2'd1:    rd_target = reload_q;
            2'd2:    rd_target = {{(DATA_W-1){1'b0}}, pend_q};
            default: rd_target = '0;
         endcase
      end
   end

   // Timer: a RELOAD write reloads the counter; expiry beats an IRQSTAT clear.
   always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (reload_q == '0)            cnt_d = '0;
      else if (cnt_q == DATA_W'(1))  cnt_d = reload_q;
      else                           cnt_d = cnt_q - DATA_W'(1);
      if (reg_we && addr_q[1:0] == 2'd1) cnt_d  = DataOut;
      if (reg_we && addr_q[1:0] == 2'd2) pend_d = 1'b0;
      if (expire)                        pend_d = 1'b1;
   end

   always_ff @(posedge Clock) begin
      if (ram_we) ram_q[addr_q[7:0]] <= DataOut;
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wcnt_q    <= '0;
         waitcfg_q <= 2'b01;
         nwait_q   <= 1'b1;
         nirq_q    <= 1'b1;
         rdata_q   <= '0;
         reload_q  <= '0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         nirq_q <= ~pend_q;
         if (reg_we && addr_q[1:0] == 2'd0) waitcfg_q <= DataOut[1:0];
         if (reg_we && addr_q[1:0] == 2'd1) reload_q  <= DataOut;
         if (Ale) begin
            addr_q  <= DataOut;
            wcnt_q  <= waitcfg_q;
            nwait_q <= 1'b1;
            state_q <= ADDR;
         end else begin
            case (state_q)
               IDLE: begin
               end
               ADDR, WAIT: begin
                  // ADDR waits for nMe to assert; losing nMe once waiting aborts.
                  if (nMe) begin
                     if (state_q == WAIT) begin
                        nwait_q <= 1'b1;
                        state_q <= IDLE;
                     end
                  end else if (wcnt_q != 2'd0) begin
                     wcnt_q  <= wcnt_q - 2'd1;
                     nwait_q <= 1'b0;
                     state_q <= WAIT;
                  end else if (defer) begin
                     nwait_q <= 1'b0;
                     state_q <= WAIT;
                  end else begin
                     if (RnW) rdata_q <= rd_target;
                     nwait_q <= 1'b1;
                     state_q <= DONE;
                  end
               end
               DONE: begin
                  if (nMe) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign DataIn = (RnW && !nOe) ? rdata_q : '0;
   assign nWait  = nwait_q;
   assign nIrq   = nirq_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: bus cycles, wait states, aliasing,
// write deferral, aborts, reset and the timer interrupt.
module tb_mem_responder;

   logic        Clock = 1'b0;
   logic        nReset = 1'b0;
   logic [15:0] DataOut = '0;
   logic        Ale = 1'b0;
   logic        nMe = 1'b1;
   logic        RnW = 1'b1;
   logic        nOe = 1'b0;
   logic        Enb = 1'b0;
   logic [15:0] DataIn;
   logic        nWait;
   logic        nIrq;

   int npass = 0;
   int ntotal = 0;
   int cyc = 0;

   mem_responder dut (
      .Clock(Clock), .nReset(nReset), .DataOut(DataOut), .Ale(Ale), .nMe(nMe),
      .RnW(RnW), .nOe(nOe), .Enb(Enb), .DataIn(DataIn), .nWait(nWait), .nIrq(nIrq)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc1();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Full bus cycle up to the negedge after nWait returns high; nMe stays low.
   task automatic access(input logic rnw, input logic [15:0] a, input logic [15:0] wd,
                         output int lows);
      bit done;
      Ale = 1'b1; DataOut = a; nMe = 1'b1; Enb = 1'b0; RnW = rnw;
      cyc1();
      Ale = 1'b0; nMe = 1'b0; DataOut = wd; Enb = !rnw;
      lows = 0;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         cyc1();
         if (nWait === 1'b0) lows++;
         else done = 1'b1;
      end
      check("access_timeout", 16'(done), 16'h1);
   endtask

   task automatic end_cycle();
      nMe = 1'b1; Enb = 1'b0; RnW = 1'b1;
      cyc1();
   endtask

   task automatic wr(input string tag, input logic [15:0] a, input logic [15:0] d, input int explows);
      int l;
      access(1'b0, a, d, l);
      check({tag, "_lows"}, 16'(l), 16'(explows));
      end_cycle();
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp, input int explows);
      int l;
      access(1'b1, a, 16'h0000, l);
      check({tag, "_lows"}, 16'(l), 16'(explows));
      check({tag, "_data"}, DataIn, exp);
      end_cycle();
   endtask

   initial begin
      int l;
      int w;
      repeat (3) @(negedge Clock);
      check("rst_nwait", 16'(nWait), 16'h1);
      check("rst_nirq", 16'(nIrq), 16'h1);
      check("rst_datain", DataIn, 16'h0000);
      check("rst_state", 16'(dut.state_q), 16'h0);
      nReset = 1'b1;
      cyc1();

      // Default WAITCFG is 1: one wait cycle per access.
      rd("waitcfg_dflt", 16'h8000, 16'h0001, 1);
      wr("waitcfg0", 16'h8000, 16'h0000, 1);
      wr("wr_1234", 16'h0010, 16'h1234, 0);
      access(1'b1, 16'h0010, 16'h0000, l);
      check("rd_1234_lows", 16'(l), 16'h0);
      check("rd_1234_oe0", DataIn, 16'h1234);
      nOe = 1'b1; #1;
      check("rd_1234_oe1", DataIn, 16'h0000);
      nOe = 1'b0;
      end_cycle();

      wr("waitcfg3", 16'h8000, 16'h0003, 0);
      rd("rd_ws3", 16'h0010, 16'h1234, 3);
      rd("waitcfg3_rb", 16'h8000, 16'h0003, 3);

      wr("wr_alias", 16'h0110, 16'hBEEF, 3);
      rd("rd_alias", 16'h0010, 16'hBEEF, 3);
      wr("wr_8003", 16'h8003, 16'h5555, 3);
      rd("rd_8003", 16'h8003, 16'h0000, 3);
      wr("waitcfg0b", 16'h8000, 16'h0000, 3);

      // Write held off by Enb=0 for two edges, commits on the first Enb=1 edge.
      Ale = 1'b1; DataOut = 16'h0030; nMe = 1'b1; Enb = 1'b0; RnW = 1'b0;
      cyc1();
      Ale = 1'b0; nMe = 1'b0; DataOut = 16'h1111;
      cyc1();
      check("defer_w1", 16'(nWait), 16'h0);
      cyc1();
      check("defer_w2", 16'(nWait), 16'h0);
      DataOut = 16'hA5A5; Enb = 1'b1;
      cyc1();
      check("defer_commit", 16'(nWait), 16'h1);
      end_cycle();
      rd("rd_defer", 16'h0030, 16'hA5A5, 0);

      wr("wr_0f0f", 16'h0020, 16'h0F0F, 0);
      wr("waitcfg2", 16'h8000, 16'h0002, 0);
      rd("rd_0f0f", 16'h0020, 16'h0F0F, 2);

      // nMe dropped while waiting: abandon the write.
      Ale = 1'b1; DataOut = 16'h0020; nMe = 1'b1; Enb = 1'b0; RnW = 1'b0;
      cyc1();
      Ale = 1'b0; nMe = 1'b0; DataOut = 16'hDEAD; Enb = 1'b1;
      cyc1();
      check("abort_wait", 16'(nWait), 16'h0);
      nMe = 1'b1;
      cyc1();
      check("abort_nwait", 16'(nWait), 16'h1);
      check("abort_state", 16'(dut.state_q), 16'h0);
      end_cycle();
      rd("abort_mem", 16'h0020, 16'h0F0F, 2);

      // Reset pulsed while waiting.
      Ale = 1'b1; DataOut = 16'h0020; nMe = 1'b1; Enb = 1'b0; RnW = 1'b0;
      cyc1();
      Ale = 1'b0; nMe = 1'b0; DataOut = 16'hDEAD; Enb = 1'b1;
      cyc1();
      check("rstmid_wait", 16'(nWait), 16'h0);
      nReset = 1'b0; #1;
      check("rstmid_nwait", 16'(nWait), 16'h1);
      check("rstmid_nirq", 16'(nIrq), 16'h1);
      RnW = 1'b1; #1;
      check("rstmid_rdata", DataIn, 16'h0000);
      check("rstmid_state", 16'(dut.state_q), 16'h0);
      cyc1();
      nReset = 1'b1; nMe = 1'b1; Enb = 1'b0;
      cyc1();
      rd("rstmid_mem", 16'h0020, 16'h0F0F, 1);
      rd("rstmid_reload", 16'h8001, 16'h0000, 1);

      // Timer with RELOAD=4.
      wr("waitcfg0c", 16'h8000, 16'h0000, 1);
      access(1'b0, 16'h8001, 16'h0004, l);
      w = cyc;
      nMe = 1'b1; Enb = 1'b0; RnW = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc1();
         check($sformatf("irq_edge%0d", k), 16'(nIrq), (k == 5) ? 16'h0 : 16'h1);
      end
      rd("irqstat_rd", 16'h8002, 16'h0001, 0);

      // IRQSTAT write midway between expiries clears the interrupt.
      for (int i = 0; i < 8 && ((cyc + 2 - w) % 4) != 2; i++) @(negedge Clock);
      access(1'b0, 16'h8002, 16'h0000, l);
      nMe = 1'b1; Enb = 1'b0; RnW = 1'b1;
      cyc1();
      check("irq_cleared", 16'(nIrq), 16'h1);
      cyc1();
      cyc1();
      check("irq_again", 16'(nIrq), 16'h0);

      // IRQSTAT write on the expiry edge: pending stays set.
      for (int i = 0; i < 8 && ((cyc + 2 - w) % 4) != 0; i++) @(negedge Clock);
      access(1'b0, 16'h8002, 16'h0000, l);
      nMe = 1'b1; Enb = 1'b0; RnW = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc1();
         check($sformatf("irq_coinc%0d", k), 16'(nIrq), 16'h0);
      end

      wr("reload0", 16'h8001, 16'h0000, 0);
      wr("irq_clr_final", 16'h8002, 16'h0000, 0);
      cyc1();
      check("irq_stopped", 16'(nIrq), 16'h1);
      rd("irqstat_zero", 16'h8002, 16'h0000, 0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
